// File: rtl/opendap_mem_ap_pkg.sv
`default_nettype none
// ============================================================================
// opendap_mem_ap_pkg : register map, CSW fields and APB FSM encoding for MEM-AP
// Revision: 1.0
// ============================================================================
package opendap_mem_ap_pkg;

  localparam logic [7:0] OFF_CSW  = 8'h00;
  localparam logic [7:0] OFF_TAR  = 8'h04;
  localparam logic [7:0] OFF_DRW  = 8'h0C;
  localparam logic [7:0] OFF_BD0  = 8'h10;
  localparam logic [7:0] OFF_BD1  = 8'h14;
  localparam logic [7:0] OFF_BD2  = 8'h18;
  localparam logic [7:0] OFF_BD3  = 8'h1C;
  localparam logic [7:0] OFF_CFG  = 8'hF4;
  localparam logic [7:0] OFF_BASE = 8'hF8;
  localparam logic [7:0] OFF_IDR  = 8'hFC;

  localparam int CSW_DBGSWEN     = 31;
  localparam int CSW_TRINPROG    = 7;
  localparam int CSW_DEVICEEN    = 6;
  localparam int CSW_ADDRINC_LSB = 4;
  localparam logic [2:0] CSW_SIZE_WORD = 3'b010;

  localparam logic [1:0] ADDRINC_OFF    = 2'b00;
  localparam logic [1:0] ADDRINC_SINGLE = 2'b01;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/opendap_mem_ap_apb_fsm.sv
`default_nettype none
// ============================================================================
// opendap_mem_ap_apb_fsm : single 32-bit APB3 master transfer engine
// Revision: 1.0
// ============================================================================
module opendap_mem_ap_apb_fsm
  import opendap_mem_ap_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              swclk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [31:0]       pwdata_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e        state_q, state_d;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;

  // Address/data are captured only on start so they stay stable for the whole transfer
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= APB_IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_i && state_q == APB_IDLE) begin
        pwrite_q <= write_i;
        paddr_q  <= addr_i;
        pwdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      APB_IDLE:   if (start_i) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: begin
        if (pready_i) begin
          done_o  = 1'b1;
          state_d = APB_IDLE;
        end
      end
      default:    state_d = APB_IDLE;
    endcase
  end

  assign psel_o    = (state_q != APB_IDLE);
  assign penable_o = (state_q == APB_ACCESS);
  assign busy_o    = psel_o;
  assign err_o     = done_o & pslverr_i;
  assign rdata_o   = prdata_i;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule
`default_nettype wire

// File: rtl/opendap_mem_ap_apb.sv
`default_nettype none
// ============================================================================
// opendap_mem_ap_apb : MEM-AP register file and decode, DRW/BDn mapped to APB3
// Revision: 1.0
// ============================================================================
module opendap_mem_ap_apb
  import opendap_mem_ap_pkg::*;
#(
  parameter logic [7:0]  APSEL  = 8'd0,
  parameter logic [31:0] IDR    = 32'h04770002,
  parameter logic [31:0] BASE   = 32'h00000003,
  parameter int          ADDR_W = 32
) (
  input  logic              swclk,
  input  logic              rst_n,
  input  logic [7:0]        ap_sel,
  input  logic [5:0]        ap_addr,
  input  logic [31:0]       ap_wdata,
  input  logic              ap_wen,
  input  logic              ap_ren,
  output logic [31:0]       ap_rdata,
  output logic              ap_rdy,
  output logic              ap_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  logic [1:0]  addrinc_q, addrinc_d;
  logic [31:0] tar_q, tar_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q;
  logic        drw_q;

  logic [7:0]  offset;
  logic        accept, is_drw, is_bd, is_apb, apb_start;
  logic [31:0] apb_addr32, csw_val, reg_rdata;
  logic        fsm_busy, fsm_done, fsm_err;
  logic [31:0] fsm_rdata;

  assign offset     = {ap_addr, 2'b00};
  assign accept     = (ap_sel == APSEL) && ap_rdy && (ap_wen || ap_ren);
  assign is_drw     = (offset == OFF_DRW);
  assign is_bd      = (offset[7:4] == OFF_BD0[7:4]);
  assign is_apb     = is_drw || is_bd;
  assign apb_start  = accept && is_apb;
  assign apb_addr32 = is_bd ? {tar_q[31:4], offset[3:2], 2'b00} : tar_q;

  always_comb begin
    csw_val                                = 32'h0;
    csw_val[CSW_DBGSWEN]                   = 1'b1;
    csw_val[CSW_TRINPROG]                  = !ap_rdy;
    csw_val[CSW_DEVICEEN]                  = 1'b1;
    csw_val[CSW_ADDRINC_LSB +: 2]          = addrinc_q;
    csw_val[2:0]                           = CSW_SIZE_WORD;
  end

  always_comb begin
    case (offset)
      OFF_CSW:  reg_rdata = csw_val;
      OFF_TAR:  reg_rdata = tar_q;
      OFF_BASE: reg_rdata = BASE;
      OFF_IDR:  reg_rdata = IDR;
      default:  reg_rdata = 32'h0;
    endcase
  end

  // ap_wen has priority over ap_ren when both strobe together
  always_comb begin
    addrinc_d = addrinc_q;
    tar_d     = tar_q;
    rdata_d   = rdata_q;
    if (accept && !is_apb) begin
      if (ap_wen) begin
        if (offset == OFF_CSW) addrinc_d = ap_wdata[CSW_ADDRINC_LSB +: 2];
        if (offset == OFF_TAR) tar_d     = ap_wdata;
      end else begin
        rdata_d = reg_rdata;
      end
    end
    if (fsm_done) begin
      if (!pwrite) rdata_d = fsm_rdata;
      if (drw_q && !fsm_err && addrinc_q == ADDRINC_SINGLE)
        tar_d = {tar_q[31:12], tar_q[11:0] + 12'd4};
    end
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      addrinc_q <= ADDRINC_OFF;
      tar_q     <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      drw_q     <= 1'b0;
    end else begin
      addrinc_q <= addrinc_d;
      tar_q     <= tar_d;
      rdata_q   <= rdata_d;
      err_q     <= fsm_err;
      if (apb_start) drw_q <= is_drw;
    end
  end

  opendap_mem_ap_apb_fsm #(
    .ADDR_W (ADDR_W)
  ) u_apb_fsm (
    .swclk     (swclk),
    .rst_n     (rst_n),
    .start_i   (apb_start),
    .write_i   (ap_wen),
    .addr_i    (apb_addr32[ADDR_W-1:0]),
    .wdata_i   (ap_wdata),
    .busy_o    (fsm_busy),
    .done_o    (fsm_done),
    .err_o     (fsm_err),
    .rdata_o   (fsm_rdata),
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .paddr_o   (paddr),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr)
  );

  assign ap_rdy   = !fsm_busy;
  assign ap_err   = err_q;
  assign ap_rdata = rdata_q;

endmodule
`default_nettype wire
